// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 4-stage RV32I pipeline
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYC   = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_if2id,
  input  logic             ld_exe,
  input  logic [4:0]       rd_exe,
  input  logic             redirect_exe,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ide_wait,
  output logic             flush,
  output logic             exe_hold,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, LD_STALL, FLUSH, MEM_WAIT} state_t;

  state_t             state_q, state_d;
  logic [2:0]         fcnt_q, fcnt_d;
  logic [2:0]         pend_q, pend_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic uses_rs1, uses_rs2, hz, memwait, redirect_acc;
  logic ph, fl, iw;
  logic [4:0] rs1, rs2;
  logic unused_instr_bits;

  assign unused_instr_bits = ^{instr_if2id[31:25], instr_if2id[14:7]};
  assign rs1     = instr_if2id[19:15];
  assign rs2     = instr_if2id[24:20];
  assign memwait = dmem_req & ~dmem_ack;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (instr_if2id[6:0])
      7'b0110011, 7'b0100011, 7'b1100011: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      7'b0000011, 7'b0010011, 7'b1100111: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign hz = ld_exe & (rd_exe != 5'd0) &
              ((uses_rs1 & (rs1 == rd_exe)) | (uses_rs2 & (rs2 == rd_exe)));

  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    pend_d       = pend_q;
    tmo_d        = tmo_q;
    mem_err_d    = mem_err_q;
    ph           = 1'b0;
    fl           = 1'b0;
    iw           = 1'b0;
    redirect_acc = 1'b0;
    case (state_q)
      RUN, LD_STALL: begin
        if (memwait) begin
          ph      = 1'b1;
          state_d = MEM_WAIT;
          tmo_d   = TMO_W'(1);
          pend_d  = 3'd0;
        end else if (redirect_exe) begin
          fl           = 1'b1;
          iw           = 1'b1;
          redirect_acc = 1'b1;
          if (FLUSH_CYC > 1) begin
            state_d = FLUSH;
            fcnt_d  = 3'(FLUSH_CYC - 1);
          end else begin
            state_d = RUN;
          end
        end else if (state_q == RUN && hz) begin
          ph      = 1'b1;
          iw      = 1'b1;
          state_d = LD_STALL;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (memwait) begin
          // remaining flush cycles resume once the memory access finishes
          ph      = 1'b1;
          pend_d  = fcnt_q;
          state_d = MEM_WAIT;
          tmo_d   = TMO_W'(1);
        end else begin
          fl = 1'b1;
          iw = 1'b1;
          if (redirect_exe) begin
            redirect_acc = 1'b1;
            fcnt_d       = 3'(FLUSH_CYC - 1);
          end else if (fcnt_q == 3'd1) begin
            state_d = RUN;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
      end
      MEM_WAIT: begin
        if (dmem_ack || tmo_q == TMO_W'(MEM_TIMEOUT)) begin
          if (!dmem_ack) mem_err_d = 1'b1;
          fcnt_d  = pend_q;
          state_d = (pend_q != 3'd0) ? FLUSH : RUN;
        end else begin
          ph    = 1'b1;
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ph && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect_acc && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      fcnt_q      <= 3'd0;
      pend_q      <= 3'd0;
      tmo_q       <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      pend_q      <= pend_d;
      tmo_q       <= tmo_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // outputs are combinational, so gate them to stay quiet while rst is high
  assign pc_hold   = ph & ~rst;
  assign ifid_hold = ph & ~rst;
  assign exe_hold  = ph & ~rst & (state_q == MEM_WAIT || memwait);
  assign ide_wait  = iw & ~rst;
  assign flush     = fl & ~rst;
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 16;
  localparam logic [4:0] ZERO = 5'b00000;  // {pc_hold,ifid_hold,ide_wait,flush,exe_hold}
  localparam logic [4:0] HZ   = 5'b11100;
  localparam logic [4:0] FL   = 5'b00110;
  localparam logic [4:0] HOLD = 5'b11001;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      instr_if2id;
  logic             ld_exe, redirect_exe, dmem_req, dmem_ack;
  logic [4:0]       rd_exe;
  logic             pc_hold, ifid_hold, ide_wait, flush, exe_hold, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  pipe_hazard_ctrl #(.FLUSH_CYC(2), .MEM_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr_if2id(instr_if2id), .ld_exe(ld_exe),
    .rd_exe(rd_exe), .redirect_exe(redirect_exe), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .ide_wait(ide_wait), .flush(flush), .exe_hold(exe_hold), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {pc_hold, ifid_hold, ide_wait, flush, exe_hold};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // inputs are already applied; check this cycle's outputs, then move past the next edge
  task automatic cyc(input string tag, input logic [4:0] exp);
    #1;
    chk_out(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnts(input string tag);
    chk_val({tag, "_stall"}, int'(stall_cnt), exp_stall);
    chk_val({tag, "_flush"}, int'(flush_cnt), exp_flush);
  endtask

  initial begin
    rst = 1'b1; instr_if2id = 32'h00728333; ld_exe = 1'b1; rd_exe = 5'd5;
    redirect_exe = 1'b1; dmem_req = 1'b0; dmem_ack = 1'b0;
    #2;
    chk_out("reset_outputs", ZERO);
    chk_cnts("reset");
    chk_val("reset_mem_err", int'(mem_err), 0);
    @(posedge clk); #1;
    rst = 1'b0; redirect_exe = 1'b0; ld_exe = 1'b0;

    // load-use: lw x5 ; add x6,x5,x7
    ld_exe = 1'b1; rd_exe = 5'd5; instr_if2id = 32'h00728333;
    cyc("ld_use_stall", HZ);
    cyc("ld_stall_gap", ZERO);
    ld_exe = 1'b0;
    cyc("after_ld", ZERO);
    exp_stall = 1; chk_cnts("ld_use");

    ld_exe = 1'b1; rd_exe = 5'd0; instr_if2id = 32'h00700333;
    cyc("rd_x0_nostall", ZERO);
    rd_exe = 5'd5; instr_if2id = 32'h005282B7;
    cyc("lui_nostall", ZERO);
    instr_if2id = 32'h00508313;
    cyc("addi_rs2field_nostall", ZERO);
    chk_cnts("no_hazard");
    instr_if2id = 32'h0050A023;
    cyc("sw_rs2_stall", HZ);
    cyc("sw_stall_gap", ZERO);
    ld_exe = 1'b0; instr_if2id = 32'h0;
    exp_stall = 2; chk_cnts("sw");

    // redirect flushes, then a redirect that extends the flush window
    redirect_exe = 1'b1;
    cyc("redir_c1", FL);
    redirect_exe = 1'b0;
    cyc("redir_c2", FL);
    cyc("redir_done", ZERO);
    exp_flush = 1; chk_cnts("redir");
    redirect_exe = 1'b1;
    cyc("redir2_c1", FL);
    cyc("redir2_c2_again", FL);
    redirect_exe = 1'b0;
    cyc("redir2_c3", FL);
    cyc("redir2_done", ZERO);
    exp_flush = 3; chk_cnts("redir2");

    // memory wait with ack after 4 cycles
    dmem_req = 1'b1; dmem_ack = 1'b1;
    cyc("req_ack_same_cycle", ZERO);
    dmem_ack = 1'b0;
    for (int i = 0; i < 4; i++) cyc("mem_hold", HOLD);
    dmem_ack = 1'b1;
    cyc("mem_ack", ZERO);
    dmem_req = 1'b0; dmem_ack = 1'b0;
    cyc("mem_done", ZERO);
    exp_stall = 6; chk_cnts("mem");

    // redirect, memwait during first flush cycle, ack three cycles later
    redirect_exe = 1'b1;
    cyc("mix_flush", FL);
    redirect_exe = 1'b0; dmem_req = 1'b1;
    cyc("mix_hold1", HOLD);
    redirect_exe = 1'b1;
    cyc("mix_hold2_redir_ignored", HOLD);
    redirect_exe = 1'b0;
    cyc("mix_hold3", HOLD);
    dmem_ack = 1'b1;
    cyc("mix_ack", ZERO);
    dmem_req = 1'b0; dmem_ack = 1'b0;
    cyc("mix_resume_flush", FL);
    cyc("mix_done", ZERO);
    exp_stall = 9; exp_flush = 4; chk_cnts("mix");

    // timeout: no ack ever
    dmem_req = 1'b1;
    for (int i = 0; i < 8; i++) cyc("tmo_hold", HOLD);
    dmem_req = 1'b0;
    cyc("tmo_abort", ZERO);
    chk_val("tmo_mem_err", int'(mem_err), 1);
    exp_stall = 17; chk_cnts("tmo");
    cyc("tmo_run", ZERO);
    chk_val("mem_err_sticky", int'(mem_err), 1);

    // asynchronous reset in the middle of MEM_WAIT
    dmem_req = 1'b1;
    cyc("rst_pre_hold1", HOLD);
    cyc("rst_pre_hold2", HOLD);
    #2;
    rst = 1'b1;
    #1;
    chk_out("rst_mid_outputs", ZERO);
    exp_stall = 0; exp_flush = 0; chk_cnts("rst_mid");
    chk_val("rst_mid_mem_err", int'(mem_err), 0);
    @(posedge clk); #1;
    rst = 1'b0; dmem_req = 1'b0;
    cyc("post_rst_idle", ZERO);
    chk_val("post_rst_mem_err", int'(mem_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 4-stage RV32I pipeline (IF, ID, EXE, MEM/WB).
- Watches the instruction in IF/ID, the load in ID/EXE, branch/jump redirects resolved in EXE, and the data-memory handshake.
- Drives PC hold, IF/ID hold, the decoder bubble (ide_wait), the IF/ID kill and the EXE hold.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout error flag.

Parameters:
FLUSH_CYC, 2, cycles of IF/ID kill after an accepted redirect (1..7)
MEM_TIMEOUT, 64, max cycles in MEM_WAIT before abort (>=2)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_if2id  in  32  instruction currently in IF/ID
ld_exe  in  1  ID/EXE holds a load with reg_write=1
rd_exe  in  5  destination register of the ID/EXE instruction
redirect_exe  in  1  taken branch, jal or jalr resolved in EXE this cycle
dmem_req  in  1  MEM stage has an outstanding data access
dmem_ack  in  1  data memory completes the access this cycle
pc_hold  out  1  freeze PC
ifid_hold  out  1  freeze IF/ID register
ide_wait  out  1  decoder stall: inject bubble into ID/EXE
flush  out  1  kill the IF/ID instruction (convert to bubble)
exe_hold  out  1  freeze ID/EXE and EXE/MEM
mem_err  out  1  sticky: MEM_WAIT timed out
stall_cnt  out  CNT_W  cycles with pc_hold=1, saturating
flush_cnt  out  CNT_W  accepted redirects, saturating

Behaviour:
- Reset (rst=1, asynchronous): state=RUN, all counters 0, mem_err=0, all outputs 0 while rst is high.
- Control outputs are combinational from state and current inputs; state and counters are registered on the rising edge of clk.
- Source decode from instr_if2id[6:0]:
  - 0110011, 0100011, 1100011: use rs1 ([19:15]) and rs2 ([24:20]).
  - 0000011, 0010011, 1100111: use rs1 only.
  - 0110111, 0010111, 1101111, and any other opcode: use no sources.
- Load-use hazard (hz) = ld_exe & rd_exe!=0 & ((uses_rs1 & rs1==rd_exe) | (uses_rs2 & rs2==rd_exe)).
- memwait = dmem_req & ~dmem_ack.
- State RUN (priority memwait > redirect_exe > hz):
  - memwait: pc_hold=ifid_hold=exe_hold=1, ide_wait=0; next state MEM_WAIT, tmo=1, pend=0.
  - redirect_exe: flush=1, ide_wait=1; flush_cnt+1; if FLUSH_CYC>1, next state FLUSH with fcnt=FLUSH_CYC-1, else stay in RUN.
  - hz: pc_hold=ifid_hold=ide_wait=1; next state LD_STALL.
  - none of the above: all outputs 0.
- State LD_STALL: one cycle with all outputs 0 and hz ignored, then RUN.
  - memwait and redirect_exe are still evaluated exactly as in RUN.
- State FLUSH: flush=ide_wait=1; fcnt decrements; at fcnt==1, next state RUN.
  - redirect_exe in FLUSH: flush_cnt+1, fcnt reloads to FLUSH_CYC-1.
  - memwait in FLUSH: same outputs as RUN memwait with flush=0; pend=fcnt; next state MEM_WAIT.
- State MEM_WAIT: pc_hold=ifid_hold=exe_hold=1 while dmem_ack=0; tmo increments each cycle.
  - dmem_ack=1: holds drop in that same cycle; next state FLUSH if pend!=0 (fcnt=pend), else RUN.
  - tmo==MEM_TIMEOUT without ack: mem_err<=1 (sticky until rst), holds drop, same exit as ack.
  - redirect_exe is ignored in MEM_WAIT because EXE is frozen.
- stall_cnt increments on every cycle with pc_hold=1; both counters stop at all-ones.
- Simultaneous dmem_req & dmem_ack in RUN: no stall.

Test Plan:
- lw x5 in ID/EXE (ld_exe=1, rd_exe=5), IF/ID=add x6,x5,x7 (0x00728333) -> exactly 1 cycle pc_hold=ifid_hold=ide_wait=1, then all 0; stall_cnt=1.
- Same, but rd_exe=0, or IF/ID=lui x5 -> no stall; stall_cnt stays 0.
- redirect_exe pulse with FLUSH_CYC=2 -> flush=ide_wait=1 for 2 consecutive cycles; flush_cnt=1; a second redirect in cycle 2 extends flush to cycle 3.
- dmem_req=1 with ack after 4 cycles -> holds high for 4 cycles, low on the ack cycle, stall_cnt=4.
- redirect, then memwait during the first FLUSH cycle, ack 3 cycles later -> 1 flush, 3 hold cycles, then 1 remaining flush cycle.
- MEM_TIMEOUT=8, ack never given -> holds for 8 cycles, then mem_err=1 and RUN; assert rst mid-MEM_WAIT -> all outputs and counters 0 immediately.
